// File: rtl/sync_link_ctrl_pkg.sv
// Shared definitions for the byte-lane sync controller: lane state encoding and default comma symbol.
package sync_link_ctrl_pkg;

  typedef enum logic [1:0] {
    LOS   = 2'd0,
    ACQ   = 2'd1,
    SYNC  = 2'd2,
    CHECK = 2'd3
  } link_state_e;

  localparam logic [7:0] COMMA_DEF = 8'hBC;

  function automatic logic is_locked(input link_state_e s);
    return (s == SYNC) || (s == CHECK);
  endfunction

endpackage

// File: rtl/sync_link_ctrl_timeout_cnt.sv
// Acquisition watchdog: counts enabled cycles, flags terminal count combinationally and wraps to 0.
module link_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_4f,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt;

  // tc does not depend on clr, so the caller may derive clr from its next state
  assign tc = en && (to_cnt == TC_VAL);

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)
      to_cnt <= '0;
    else if (clr || tc)
      to_cnt <= '0;
    else if (en)
      to_cnt <= to_cnt + TW'(1);
  end

endmodule

// File: rtl/sync_link_ctrl.sv
// Byte-lane comma lock controller with loss hysteresis and acquisition timeout.
// Optional saturating error counter enabled by defining SYNC_LINK_ERR_COUNT_EN.
module sync_link_ctrl
  import sync_link_ctrl_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] COMMA      = COMMA_DEF,
  parameter int                ACQ_COUNT  = 4,
  parameter int                LOSS_COUNT = 3,
  parameter int                GOOD_COUNT = 2,
  parameter int                TIMEOUT    = 64,
  parameter int                ERR_W      = 8
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              active_in,
  input  logic              err_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sync_ok,
  output logic [1:0]        state_o,
  output logic              resync_req
`ifdef SYNC_LINK_ERR_COUNT_EN
  ,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
`endif
);

  localparam int AW = $clog2(ACQ_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam int GW = $clog2(GOOD_COUNT + 1);
  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_COUNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_COUNT - 1);

  link_state_e       state_q, state_d;
  logic [AW-1:0]     acq_cnt, acq_d;
  logic [BW-1:0]     bad_cnt, bad_d;
  logic [GW-1:0]     good_cnt, good_d;
  logic              bad, comma, good, locked, fwd, tc, lol, to_en, to_clr;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1, sync_p1, rs_p1;

  assign bad    = !active_in || err_in;
  assign good   = !bad;
  assign comma  = good && (data_in == COMMA);
  assign locked = is_locked(state_q);
  assign fwd    = locked && good && (data_in != COMMA);
  assign lol    = (state_q == CHECK) && (state_d == LOS);
  assign to_en  = !locked;
  assign to_clr = locked || (state_d == SYNC);

  link_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_4f (clk_4f),
    .reset  (reset),
    .clr    (to_clr),
    .en     (to_en),
    .tc     (tc)
  );

  always_comb begin
    state_d = state_q;
    acq_d   = acq_cnt;
    bad_d   = bad_cnt;
    good_d  = good_cnt;
    case (state_q)
      LOS: if (comma) begin
        state_d = ACQ;
        acq_d   = AW'(1);
      end
      ACQ: if (comma) begin
        if (acq_cnt == ACQ_LAST) begin
          state_d = SYNC;
          acq_d   = '0;
        end else begin
          acq_d = acq_cnt + AW'(1);
        end
      end else begin
        state_d = LOS;
        acq_d   = '0;
      end
      SYNC: if (bad) begin
        state_d = CHECK;
        bad_d   = BW'(1);
        good_d  = '0;
      end
      CHECK: if (bad) begin
        good_d = '0;
        if (bad_cnt == LOSS_LAST) begin
          state_d = LOS;
          bad_d   = '0;
        end else begin
          bad_d = bad_cnt + BW'(1);
        end
      end else if (good_cnt == GOOD_LAST) begin
        state_d = SYNC;
        bad_d   = '0;
        good_d  = '0;
      end else begin
        good_d = good_cnt + GW'(1);
      end
      default: state_d = LOS;
    endcase
    // A stalled acquisition restarts from scratch even if this byte is a comma
    if (tc) begin
      state_d = LOS;
      acq_d   = '0;
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q  <= LOS;
      acq_cnt  <= '0;
      bad_cnt  <= '0;
      good_cnt <= '0;
    end else begin
      state_q  <= state_d;
      acq_cnt  <= acq_d;
      bad_cnt  <= bad_d;
      good_cnt <= good_d;
    end
  end

  // ---- stage p1: registered forwarded byte and status ----
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
      rs_p1   <= 1'b0;
    end else begin
      vld_p1  <= fwd;
      sync_p1 <= locked;
      rs_p1   <= tc;
      if (fwd)
        data_p1 <= data_in;
    end
  end

  assign data_out   = data_p1;
  assign valid_out  = vld_p1;
  assign sync_ok    = sync_p1;
  assign resync_req = rs_p1;
  assign state_o    = state_q;

`ifdef SYNC_LINK_ERR_COUNT_EN
  logic [ERR_W-1:0] err_q;
  logic [1:0]       err_step;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [1:0] step);
    logic [ERR_W+1:0] sum;
    sum = {2'b00, a} + (ERR_W + 2)'(step);
    if (sum > {2'b00, {ERR_W{1'b1}}})
      return {ERR_W{1'b1}};
    return sum[ERR_W-1:0];
  endfunction

  // A loss-of-lock byte is both a bad byte and a lock event, so it scores twice
  assign err_step = {1'b0, locked && bad} + {1'b0, lol};

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)
      err_q <= '0;
    else if (err_clr)
      err_q <= '0;
    else
      err_q <= sat_add(err_q, err_step);
  end

  assign err_cnt = err_q;
`endif

endmodule
